// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state encodings, default width.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    localparam logic [1:0] MULDIV_MULTU = 2'b00;
    localparam logic [1:0] MULDIV_MULT  = 2'b01;
    localparam logic [1:0] MULDIV_DIVU  = 2'b10;
    localparam logic [1:0] MULDIV_DIV   = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } muldiv_state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, trial-subtract/shift (restoring) for divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] mq_nxt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum     = {1'b0, acc} + (mq[0] ? {1'b0, b} : '0);
        shifted = {acc, mq[WIDTH-1]};
        // partial remainder stays below 2*b, so the low WIDTH bits of the difference are exact
        diff    = shifted[WIDTH-1:0] - b;
        ge      = (shifted >= {1'b0, b});
        if (is_div) begin
            acc_nxt = ge ? diff : shifted[WIDTH-1:0];
            mq_nxt  = {mq[WIDTH-2:0], ge};
        end else begin
            acc_nxt = sum[WIDTH:1];
            mq_nxt  = {sum[0], mq[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer with HI/LO result registers and pipeline stall.
// Define MULDIV_SIGNED_EN to make op 01/11 signed; otherwise every op is unsigned.
//
// state | meaning
// IDLE  | waiting for start
// PREP  | take operand magnitudes, record result signs, trap divide by zero
// ITER  | WIDTH radix-2 steps, counted down to terminal count
// FIX   | apply recorded signs, write hi/lo on exit
// DONE  | one-cycle done pulse, may accept the next start
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             read_hilo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] ITER_N = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_TC = CW'(1);

    muldiv_state_t state, state_nxt;

    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mq;
    logic [CW-1:0]      cnt;
    logic               neg_q;
    logic               neg_r;
    logic               dbz_r;

    logic               is_div;
    logic               is_signed;
    logic               div_zero;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]   mq_nxt;
    logic [2*WIDTH-1:0] prod;

`ifdef MULDIV_SIGNED_EN
    assign is_signed = op_r[0];
`else
    logic unused_op0;
    assign unused_op0 = op_r[0];
    assign is_signed  = 1'b0;
`endif

    assign is_div   = op_is_div(op_r);
    assign div_zero = is_div && (b_r == '0);
    assign mag_a    = (is_signed && a_r[WIDTH-1]) ? -a_r : a_r;
    assign mag_b    = (is_signed && b_r[WIDTH-1]) ? -b_r : b_r;
    assign prod     = {acc, mq};

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc     (acc),
        .mq      (mq),
        .b       (b_r),
        .acc_nxt (acc_nxt),
        .mq_nxt  (mq_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PREP;
            PREP:    state_nxt = div_zero ? DONE : ITER;
            ITER:    if (cnt == CNT_TC) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = start ? PREP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            mq    <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dbz_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_r  <= op;
                        a_r   <= rs_data;
                        b_r   <= rt_data;
                        dbz_r <= 1'b0;
                    end
                end
                PREP: begin
                    acc   <= '0;
                    mq    <= mag_a;
                    b_r   <= mag_b;
                    cnt   <= ITER_N;
                    neg_q <= is_signed && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    neg_r <= is_signed && a_r[WIDTH-1];
                    // a zero divisor skips the iterations and returns rs unchanged in hi
                    if (div_zero) begin
                        hi    <= a_r;
                        lo    <= '1;
                        dbz_r <= 1'b1;
                    end
                end
                ITER: begin
                    acc <= acc_nxt;
                    mq  <= mq_nxt;
                    cnt <= cnt - CNT_TC;
                end
                FIX: begin
                    if (is_div) begin
                        lo <= neg_q ? -mq : mq;
                        hi <= neg_r ? -acc : acc;
                    end else begin
                        {hi, lo} <= neg_q ? -prod : prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state == PREP) || (state == ITER) || (state == FIX);
    assign done        = (state == DONE);
    assign div_by_zero = (state == DONE) && dbz_r;
    assign stall       = busy && (read_hilo || start);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: cycle-level reference model plus directed literal cases.
module tb_muldiv_sequencer;

    localparam int W   = 32;
    localparam int LAT = W + 2;   // edges from the start edge to the cycle showing done

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  rs_data = '0;
    logic [W-1:0]  rt_data = '0;
    logic          read_hilo = 1'b0;
    logic          busy, done, div_by_zero, stall;
    logic [W-1:0]  hi, lo;

    int n_pass = 0;
    int n_tot  = 0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .read_hilo   (read_hilo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .stall       (stall),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Architectural result of one op, straight from the arithmetic definition.
    task automatic ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] h, output logic [31:0] l, output bit z);
        bit          sg;
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
`ifdef MULDIV_SIGNED_EN
        sg = o[0];
`else
        sg = 1'b0;
`endif
        z = 1'b0;
        if (!o[1]) begin
            if (sg) begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = sp;
            end else begin
                up = {32'b0, a} * {32'b0, b};
            end
            h = up[63:32];
            l = up[31:0];
        end else if (b == 32'h0) begin
            h = a;
            l = 32'hFFFF_FFFF;
            z = 1'b1;
        end else if (sg) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                l = 32'h8000_0000;
                h = 32'h0;
            end else begin
                sa = $signed(a);
                sb = $signed(b);
                l = sa / sb;
                h = sa % sb;
            end
        end else begin
            l = a / b;
            h = a % b;
        end
    endtask

    // Reference model: an accepted op is busy for its latency, then shows done and its results.
    int          cyc = 0;
    int          k_acc = 0;
    int          m_lat = 0;
    bit          active = 1'b0;
    bit          exp_busy = 1'b0, exp_done = 1'b0, exp_dbz = 1'b0;
    logic [31:0] exp_hi = '0, exp_lo = '0, pend_hi = '0, pend_lo = '0;
    bit          pend_dbz = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            active   = 1'b0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_dbz  = 1'b0;
            exp_hi   = '0;
            exp_lo   = '0;
        end else begin
            cyc++;
            if (start && !exp_busy) begin
                ref_result(op, rs_data, rt_data, pend_hi, pend_lo, pend_dbz);
                k_acc  = cyc;
                m_lat  = pend_dbz ? 1 : LAT;
                active = 1'b1;
            end
            exp_busy = active && (cyc >= k_acc) && (cyc < k_acc + m_lat);
            exp_done = active && (cyc == k_acc + m_lat);
            exp_dbz  = exp_done && pend_dbz;
            if (exp_done) begin
                exp_hi = pend_hi;
                exp_lo = pend_lo;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_busy",  busy,        exp_busy);
        chk("m_done",  done,        exp_done);
        chk("m_dbz",   div_by_zero, exp_dbz);
        chk("m_stall", stall,       exp_busy && (read_hilo || start));
        chk("m_hi",    hi,          exp_hi);
        chk("m_lo",    lo,          exp_lo);
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ex_hi, input logic [31:0] ex_lo, input bit ex_dbz,
                          input int ex_lat, input string nm);
        int lat;
        bit seen;
        @(posedge clk); #2;
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #2;
        start = 1'b0; rs_data = $urandom; rt_data = $urandom; op = 2'($urandom_range(0, 3));
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        chk({nm, "_done_seen"}, seen, 1'b1);
        if (seen) begin
            chk({nm, "_latency"}, lat,         ex_lat);
            chk({nm, "_hi"},      hi,          ex_hi);
            chk({nm, "_lo"},      lo,          ex_lo);
            chk({nm, "_dbz"},     div_by_zero, ex_dbz);
        end
    endtask

    initial begin
        int dcount;
        int sp;
        bit seen;

        #12;
        chk("rst_busy",  busy,        1'b0);
        chk("rst_done",  done,        1'b0);
        chk("rst_dbz",   div_by_zero, 1'b0);
        chk("rst_stall", stall,       1'b0);
        chk("rst_hi",    hi,          32'h0);
        chk("rst_lo",    lo,          32'h0);
        #5 reset = 1'b0;

        run_op(2'b00, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, 1'b0, LAT, "multu_max");
`ifdef MULDIV_SIGNED_EN
        run_op(2'b01, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, LAT, "mult_neg");
        run_op(2'b11, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, LAT, "div_neg");
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, LAT, "div_ovf");
`else
        run_op(2'b01, 32'hFFFF_FFFD, 32'h5, 32'h4, 32'hFFFF_FFF1, 1'b0, LAT, "mult_neg");
        run_op(2'b11, 32'hFFFF_FFF9, 32'h2, 32'h1, 32'h7FFF_FFFC, 1'b0, LAT, "div_neg");
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, LAT, "div_ovf");
`endif
        run_op(2'b10, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b1, 1, "divu_zero");
        run_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, LAT, "divu_small");

        // abort in the tenth ITER cycle
        run_op(2'b00, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, LAT, "multu_pre_rst");
        @(posedge clk); #2;
        start = 1'b1; op = 2'b00; rs_data = 32'd7; rt_data = 32'd9;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_hi",   hi,   32'h0);
        chk("abort_lo",   lo,   32'h0);
        @(posedge clk); #2 reset = 1'b0;
        dcount = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", dcount, 0);

        // read_hilo and a second start while busy, then a back-to-back start in DONE
        @(posedge clk); #2;
        start = 1'b1; op = 2'b00; rs_data = 32'hFFFF_FFFF; rt_data = 32'h2;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        read_hilo = 1'b1; start = 1'b1; op = 2'b10; rs_data = 32'h1; rt_data = 32'h0;
        @(negedge clk);
        chk("stall_busy", stall, 1'b1);
        @(posedge clk); #2;
        start = 1'b0; read_hilo = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("stall_done_seen", seen, 1'b1);
        chk("stall_hi",  hi,          32'h1);
        chk("stall_lo",  lo,          32'hFFFF_FFFE);
        chk("stall_dbz", div_by_zero, 1'b0);
        start = 1'b1; op = 2'b00; rs_data = 32'd3; rt_data = 32'd5;
        @(posedge clk); #2;
        start = 1'b0;
        sp = 1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            sp++;
        end
        chk("b2b_done_seen", seen, 1'b1);
        chk("b2b_spacing",   sp,   LAT + 1);
        chk("b2b_hi",        hi,   32'h0);
        chk("b2b_lo",        lo,   32'd15);

        // random traffic, inputs change every cycle; the model checks every output
        repeat (4000) begin
            @(posedge clk); #2;
            start     = ($urandom_range(0, 3) == 0);
            read_hilo = $urandom_range(0, 1) == 1;
            op        = 2'($urandom_range(0, 3));
            rs_data   = $urandom;
            rt_data   = $urandom;
            case ($urandom_range(0, 7))
                0: rt_data = 32'h0;
                1: begin rs_data = 32'h8000_0000; rt_data = 32'hFFFF_FFFF; end
                2: begin rs_data = 32'($urandom_range(0, 255)); rt_data = 32'($urandom_range(1, 15)); end
                3: rt_data = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
                default: ;
            endcase
        end
        start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
